// File: rtl/crc16_frame_tx.sv
// crc16_frame_tx: forwards payload bytes and appends CRC-16 (MSB first); frame counter with CRC16_FRAME_TX_STATS_EN
module crc16_frame_tx #(
    parameter logic [15:0] INIT = 16'hFFFF,
    parameter logic [15:0] POLY = 16'h1021
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [7:0]  m_data,
    output logic        m_valid,
    output logic        m_last,
    input  logic        m_ready,
    output logic        busy
`ifdef CRC16_FRAME_TX_STATS_EN
    ,
    output logic [15:0] frame_cnt
`endif
);
    typedef enum logic [1:0] {PAYLOAD, CRC_HI, CRC_LO} state_t;

    state_t      state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_valid_q, m_valid_d;
    logic        m_last_q, m_last_d;
    logic        busy_q, busy_d;
    logic        slot_free, s_hs, m_hs;

    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[15] ^ d[7-i];
            r  = {r[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
        end
        return r;
    endfunction

    assign slot_free = !m_valid_q || m_ready;
    assign s_ready   = (state_q == PAYLOAD) && slot_free;
    assign s_hs      = s_valid && s_ready;
    assign m_hs      = m_valid_q && m_ready;
    assign m_data    = m_data_q;
    assign m_valid   = m_valid_q;
    assign m_last    = m_last_q;
    assign busy      = busy_q;

    // next-state: load output register from payload or CRC halves when the slot frees up
    always_comb begin
        state_d   = state_q;
        crc_d     = crc_q;
        m_data_d  = m_data_q;
        m_valid_d = m_valid_q && !m_ready;
        m_last_d  = m_last_q && !m_ready;
        busy_d    = s_hs ? 1'b1 : (m_hs && m_last_q) ? 1'b0 : busy_q;
        case (state_q)
            PAYLOAD: if (s_hs) begin
                m_data_d  = s_data;
                m_valid_d = 1'b1;
                m_last_d  = 1'b0;
                crc_d     = crc_byte(crc_q, s_data);
                state_d   = s_last ? CRC_HI : PAYLOAD;
            end
            CRC_HI: if (slot_free) begin
                m_data_d  = crc_q[15:8];
                m_valid_d = 1'b1;
                m_last_d  = 1'b0;
                state_d   = CRC_LO;
            end
            CRC_LO: if (slot_free) begin
                m_data_d  = crc_q[7:0];
                m_valid_d = 1'b1;
                m_last_d  = 1'b1;
                crc_d     = INIT;
                state_d   = PAYLOAD;
            end
            default: state_d = PAYLOAD;
        endcase
    end

    // state and output register; reset discards any partial frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= PAYLOAD;
            crc_q     <= INIT;
            m_data_q  <= 8'h00;
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            m_data_q  <= m_data_d;
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            busy_q    <= busy_d;
        end
    end

`ifdef CRC16_FRAME_TX_STATS_EN
    logic [15:0] frame_cnt_q;
    assign frame_cnt = frame_cnt_q;

    // count completed frames on the final CRC byte handshake, wrapping naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) frame_cnt_q <= 16'h0000;
        else if (m_hs && m_last_q) frame_cnt_q <= frame_cnt_q + 16'h0001;
    end
`endif
endmodule

// File: tb/tb_crc16_frame_tx.sv
// tb_crc16_frame_tx: directed and randomized frames checked against a polynomial-division CRC model
module tb_crc16_frame_tx;
    localparam logic [15:0] INIT = 16'hFFFF;
    localparam logic [15:0] POLY = 16'h1021;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_last = 1'b0;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_last;
    logic       m_ready = 1'b1;
    logic       busy;
`ifdef CRC16_FRAME_TX_STATS_EN
    logic [15:0] frame_cnt;
`endif

    crc16_frame_tx #(.INIT(INIT), .POLY(POLY)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .busy(busy)
`ifdef CRC16_FRAME_TX_STATS_EN
        , .frame_cnt(frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int stall_viol = 0;
    int exp_frames = 0;
    logic [7:0] out_q[$];
    bit         lst_q[$];
    logic [7:0] exp_d[$];
    bit         exp_l[$];
    bit         prev_stall = 0;
    logic [7:0] prev_data;
    logic       prev_last;

    // beat collector and stall-stability watcher
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_stall = 0;
        else begin
            if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stall_viol++;
            if (m_valid && m_ready) begin
                out_q.push_back(m_data);
                lst_q.push_back(m_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // CRC as remainder of (M*x^16 + INIT*x^(8n)) mod P via long division over a bit stream
    function automatic logic [15:0] ref_crc(input logic [7:0] msg[$]);
        bit          bits[$];
        logic [16:0] r = '0;
        foreach (msg[k]) for (int b = 7; b >= 0; b--) bits.push_back(msg[k][b]);
        for (int k = 0; k < 16; k++) bits.push_back(1'b0);
        for (int k = 0; k < 16; k++) bits[k] ^= INIT[15-k];
        foreach (bits[k]) begin
            r = {r[15:0], bits[k]};
            if (r[16]) r ^= {1'b1, POLY};
        end
        return r[15:0];
    endfunction

    task automatic add_exp(input logic [7:0] f[$]);
        logic [15:0] c;
        foreach (f[k]) begin
            exp_d.push_back(f[k]);
            exp_l.push_back(1'b0);
        end
        c = ref_crc(f);
        exp_d.push_back(c[15:8]); exp_l.push_back(1'b0);
        exp_d.push_back(c[7:0]);  exp_l.push_back(1'b1);
        exp_frames++;
    endtask

    // drives bytes; returns just before the edge that takes the final byte
    task automatic send(input logic [7:0] f[$], input bit term, input bit rnd);
        int  i = 0;
        int  guard = 0;
        bit  vld;
        while (i < f.size()) begin
            @(negedge clk);
            if (rnd) m_ready = 1'($urandom_range(0, 1));
            vld     = !rnd || ($urandom_range(0, 3) != 0);
            s_valid = vld;
            s_data  = f[i];
            s_last  = term && (i == f.size() - 1);
            #1;
            if (vld && s_ready) i++;
            if (++guard > 2000) begin
                total++; bad++;
                $error("FAIL send_timeout observed=%0d expected=%0d", i, f.size());
                break;
            end
        end
    endtask

    task automatic drain(input string tag);
        int guard = 0;
        @(negedge clk);
        s_valid = 0; s_last = 0; m_ready = 1;
        while (out_q.size() < exp_d.size() || m_valid) begin
            @(negedge clk);
            if (++guard > 200) break;
        end
        chk({tag, "_len"}, out_q.size(), exp_d.size());
        if (out_q.size() == exp_d.size())
            foreach (exp_d[k]) begin
                chk(tag, out_q[k], exp_d[k]);
                chk({tag, "_last"}, 32'(lst_q[k]), 32'(exp_l[k]));
            end
        out_q.delete(); lst_q.delete(); exp_d.delete(); exp_l.delete();
    endtask

    initial begin
        logic [7:0] f[$];
        logic [7:0] one[$];
        f   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        one = '{8'h00};

        // reset values while reset is held
        #2;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 8'h00);
        chk("rst_busy", busy, 0);
        @(negedge clk); rst_n = 1;

        // "123456789" with downstream always ready
        add_exp(f);
        send(f, 1, 0);
        @(negedge clk); s_valid = 0; s_last = 0; #1;
        chk("gap_s_ready0", s_ready, 0);
        chk("busy_mid", busy, 1);
        @(negedge clk); #1;
        chk("gap_s_ready1", s_ready, 0);
        @(negedge clk); #1;
        chk("gap_s_ready2", s_ready, 1);
        chk("crc_lo_last", m_last, 1);
        chk("crc_lo_data", m_data, 8'hB1);
        @(negedge clk); #1;
        chk("busy_done", busy, 0);
        chk("seq_len", out_q.size(), 11);
        if (out_q.size() == 11) begin
            chk("seq_crc_hi", out_q[9], 8'h29);
            chk("seq_crc_lo", out_q[10], 8'hB1);
        end
        drain("seq");

        // two one-byte frames of 0x00, back to back
        add_exp(one); add_exp(one);
        send(one, 1, 0);
        send(one, 1, 0);
        drain("one");
        add_exp(one);
        send(one, 1, 0);
        @(negedge clk); s_valid = 0; s_last = 0;
        repeat (3) @(negedge clk);
        chk("one_len", out_q.size(), 3);
        if (out_q.size() == 3) begin
            chk("one_b0", out_q[0], 8'h00);
            chk("one_b1", out_q[1], 8'hE1);
            chk("one_b2", out_q[2], 8'hF0);
        end
        drain("one2");

        // random back-to-back frames with random downstream backpressure
        for (int n = 0; n < 8; n++) begin
            logic [7:0] rf[$];
            int len = $urandom_range(1, 12);
            for (int k = 0; k < len; k++) rf.push_back(8'($urandom_range(0, 255)));
            add_exp(rf);
            send(rf, 1, 1);
        end
        drain("rnd");
        chk("stall_stable", stall_viol, 0);

        // asynchronous reset four bytes into a frame
        begin
            logic [7:0] part[$];
            part = f[0:3];
            send(part, 0, 0);
        end
        @(negedge clk); s_valid = 0; #1;
        chk("pre_rst_busy", busy, 1);
        #2; rst_n = 0; #1;
        chk("arst_s_ready", s_ready, 1);
        chk("arst_m_valid", m_valid, 0);
        chk("arst_m_last", m_last, 0);
        chk("arst_m_data", m_data, 8'h00);
        chk("arst_busy", busy, 0);
`ifdef CRC16_FRAME_TX_STATS_EN
        chk("arst_frame_cnt", frame_cnt, 0);
`endif
        exp_frames = 0;
        @(negedge clk); rst_n = 1;
        out_q.delete(); lst_q.delete();
        add_exp(f);
        send(f, 1, 0);
        drain("post_rst");

        // long stall while the CRC high byte is presented
        add_exp(f);
        send(f, 1, 0);
        @(negedge clk); s_valid = 0; s_last = 0;
        @(negedge clk); m_ready = 0;
        repeat (10) @(negedge clk);
        #1;
        chk("stall_data", m_data, 8'h29);
        chk("stall_valid", m_valid, 1);
        chk("stall_s_ready", s_ready, 0);
        m_ready = 1;
        @(negedge clk); #1;
        chk("rel_data", m_data, 8'hB1);
        chk("rel_last", m_last, 1);
        chk("rel_valid", m_valid, 1);
        drain("stall");
        chk("stall_stable2", stall_viol, 0);

`ifdef CRC16_FRAME_TX_STATS_EN
        chk("frame_cnt", frame_cnt, exp_frames);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
